sar_search_8bit: RTL and testbench

SAR_SEARCH_8BIT -- requirements
Module: sar_search_8bit

---
 rtl/sar_search_8bit_if.sv | 40 ++++
 rtl/sar_search_8bit.sv | 168 ++++++++++++++++
 tb/tb_sar_search_8bit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_8bit_if.sv
// rtl/sar_search_8bit_if.sv - comparator-facing bus of the SAR search engine
//
// Purpose: groups the start request, the external comparator flags and the
// search outputs so the controller and its environment share one bundle.
// Signals:
//   start   controller-side request to begin a search
//   cmp_gt  comparator flag, unknown A > trial
//   cmp_eq  comparator flag, unknown A == trial
//   cmp_lt  comparator flag, unknown A < trial
//   trial   value presented to the comparator B input
//   busy    search in progress
//   done    one-cycle completion pulse
//   result  search outcome, held until the next done
//   found   equality confirmed
//   err     inconsistent comparator flags seen
// Modports: master = environment (drives start and flags), slave = engine.
interface sar_search_8bit_if #(
  parameter int BUS = 8
);
  logic           start;
  logic           cmp_gt;
  logic           cmp_eq;
  logic           cmp_lt;
  logic [BUS-1:0] trial;
  logic           busy;
  logic           done;
  logic [BUS-1:0] result;
  logic           found;
  logic           err;

  modport master (
    output start, cmp_gt, cmp_eq, cmp_lt,
    input  trial, busy, done, result, found, err
  );

  modport slave (
    input  start, cmp_gt, cmp_eq, cmp_lt,
    output trial, busy, done, result, found, err
  );
endinterface

// File: rtl/sar_search_8bit.sv
// rtl/sar_search_8bit.sv - successive-approximation search against an external comparator
//
// Purpose: binary-searches an unknown value A by presenting trial values to
// an external magnitude comparator, one bit per step from the MSB down, then
// confirms the decided value with a final equality check.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sar_search_8bit_if.slave (start, cmp_gt/eq/lt in; trial, busy,
//          done, result, found, err out)
// Parameters:
//   BUS     search width in bits
//   SETTLE  cycles each trial is held before the flags are sampled (min 1)
module sar_search_8bit #(
  parameter int BUS    = 8,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sar_search_8bit_if.slave   bus
);

  // Values below 1 would make the sample point undefined; treat them as 1.
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CNTW       = $clog2(SETTLE_EFF + 1);
  localparam int IDXW       = (BUS > 1) ? $clog2(BUS) : 1;

  localparam logic [CNTW-1:0] CNT_RELOAD = CNTW'(SETTLE_EFF - 1);
  localparam logic [IDXW-1:0] IDX_MSB    = IDXW'(BUS - 1);
  localparam logic [BUS-1:0]  TRIAL_MSB  = {1'b1, {(BUS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRY   = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state_q,  state_d;
  logic [BUS-1:0]  trial_q,  trial_d;
  logic [IDXW-1:0] idx_q,    idx_d;
  logic [CNTW-1:0] cnt_q,    cnt_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic [BUS-1:0]  result_q, result_d;
  logic            found_q,  found_d;
  logic            err_q,    err_d;

  logic            legal;
  logic [BUS-1:0]  decided;

  // Exactly one comparator flag may be high for a sample to be trusted.
  assign legal = (bus.cmp_gt & ~bus.cmp_eq & ~bus.cmp_lt) |
                 (~bus.cmp_gt & bus.cmp_eq & ~bus.cmp_lt) |
                 (~bus.cmp_gt & ~bus.cmp_eq & bus.cmp_lt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;

    // Current bit survives only when A is above the trial.
    decided = trial_q;
    if (bus.cmp_lt) begin
      decided[idx_q] = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = TRY;
          trial_d = TRIAL_MSB;
          idx_d   = IDX_MSB;
          cnt_d   = CNT_RELOAD;
          busy_d  = 1'b1;
          found_d = 1'b0;
          err_d   = 1'b0;
        end
      end

      TRY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!legal || bus.cmp_eq) begin
          // Illegal flags or an early equality both end the search here.
          state_d  = IDLE;
          trial_d  = '0;
          cnt_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = trial_q;
          found_d  = legal;
          err_d    = ~legal;
        end else if (idx_q != '0) begin
          trial_d                 = decided;
          trial_d[idx_q - 1'b1]   = 1'b1;
          idx_d                   = idx_q - 1'b1;
          cnt_d                   = CNT_RELOAD;
        end else begin
          // Last bit decided: hold it for one more settle window and verify.
          state_d = CHECK;
          trial_d = decided;
          cnt_d   = CNT_RELOAD;
        end
      end

      CHECK: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d  = IDLE;
          trial_d  = '0;
          cnt_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = trial_q;
          found_d  = legal & bus.cmp_eq;
          err_d    = ~(legal & bus.cmp_eq);
        end
      end

      default: begin
        state_d = IDLE;
        trial_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Trial comes straight from its register so the comparator sees no glitches.
  assign bus.trial  = trial_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search_8bit.sv
// tb/tb_sar_search_8bit.sv - directed bench for the SAR search engine
module tb_sar_search_8bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic       ill1 = 1'b0;
  logic [7:0] a1 = 8'h00;
  logic [7:0] a3 = 8'h00;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  always #5 clk = ~clk;

  sar_search_8bit_if #(.BUS(8)) if1 ();
  sar_search_8bit_if #(.BUS(8)) if3 ();

  // Comparator models with a fixed unknown A; ill1 forces gt and lt together.
  assign if1.start  = start1;
  assign if1.cmp_gt = ill1 ? 1'b1 : (a1 > if1.trial);
  assign if1.cmp_lt = ill1 ? 1'b1 : (a1 < if1.trial);
  assign if1.cmp_eq = ill1 ? 1'b0 : (a1 == if1.trial);
  assign if3.start  = start3;
  assign if3.cmp_gt = (a3 > if3.trial);
  assign if3.cmp_lt = (a3 < if3.trial);
  assign if3.cmp_eq = (a3 == if3.trial);

  sar_search_8bit #(.BUS(8), .SETTLE(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  sar_search_8bit #(.BUS(8), .SETTLE(3)) u_s3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({if1.trial, if1.busy, if1.done, if1.result, if1.found, if1.err} !== 20'h0)
      $display("FAIL reset_s1: got %h expected 0", {if1.trial, if1.busy, if1.done, if1.result, if1.found, if1.err});
    else pass_cnt++;
    total_cnt++;
    if ({if3.trial, if3.busy, if3.done, if3.result, if3.found, if3.err} !== 20'h0)
      $display("FAIL reset_s3: got %h expected 0", {if3.trial, if3.busy, if3.done, if3.result, if3.found, if3.err});
    else pass_cnt++;
    start1 = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({if1.trial, if1.busy} !== 9'h0)
      $display("FAIL reset_start_ignored: got %h expected 0", {if1.trial, if1.busy});
    else pass_cnt++;
    start1 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_illegal();
    ill1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    total_cnt++;
    if ({if1.trial, if1.busy} !== {8'h80, 1'b1})
      $display("FAIL ill_first_trial: got %h expected %h", {if1.trial, if1.busy}, {8'h80, 1'b1});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({if1.done, if1.err, if1.found, if1.result, if1.busy, if1.trial} !== {1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 8'h00})
      $display("FAIL ill_done: got %h expected %h", {if1.done, if1.err, if1.found, if1.result, if1.busy, if1.trial},
               {1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 8'h00});
    else pass_cnt++;
    ill1 = 1'b0;
    tick();
    total_cnt++;
    if ({if1.done, if1.err, if1.result} !== {1'b0, 1'b1, 8'h80})
      $display("FAIL ill_hold: got %h expected %h", {if1.done, if1.err, if1.result}, {1'b0, 1'b1, 8'h80});
    else pass_cnt++;
  endtask

  task automatic test_match_5a(input string tag);
    logic [7:0] exp_tr [0:6];
    exp_tr = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
    a1 = 8'h5A;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    total_cnt++;
    if ({if1.found, if1.err} !== 2'b00)
      $display("FAIL %s_flags_cleared: got %b expected 00", tag, {if1.found, if1.err});
    else pass_cnt++;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      total_cnt++;
      if ({if1.trial, if1.busy, if1.done} !== {exp_tr[k], 1'b1, 1'b0})
        $display("FAIL %s_trial_e%0d: got %h expected %h", tag, k, {if1.trial, if1.busy, if1.done}, {exp_tr[k], 1'b1, 1'b0});
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({if1.done, if1.result, if1.found, if1.err, if1.busy, if1.trial} !== {1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL %s_done_e7: got %h expected %h", tag, {if1.done, if1.result, if1.found, if1.err, if1.busy, if1.trial},
               {1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({if1.done, if1.result, if1.found} !== {1'b0, 8'h5A, 1'b1})
      $display("FAIL %s_pulse_e8: got %h expected %h", tag, {if1.done, if1.result, if1.found}, {1'b0, 8'h5A, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_zero();
    logic [7:0] e;
    a1 = 8'h00;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      e = 8'h80 >> k;
      total_cnt++;
      if ({if1.trial, if1.done} !== {e, 1'b0})
        $display("FAIL zero_trial_e%0d: got %h expected %h", k, {if1.trial, if1.done}, {e, 1'b0});
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({if1.done, if1.result, if1.found, if1.err} !== {1'b1, 8'h00, 1'b1, 1'b0})
      $display("FAIL zero_done_e9: got %h expected %h", {if1.done, if1.result, if1.found, if1.err}, {1'b1, 8'h00, 1'b1, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_ff();
    logic [7:0] e;
    a1 = 8'hFF;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      e = ~(8'hFF >> (k + 1));
      total_cnt++;
      if ({if1.trial, if1.done} !== {e, 1'b0})
        $display("FAIL ff_trial_e%0d: got %h expected %h", k, {if1.trial, if1.done}, {e, 1'b0});
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({if1.done, if1.result, if1.found, if1.err} !== {1'b1, 8'hFF, 1'b1, 1'b0})
      $display("FAIL ff_done_e8: got %h expected %h", {if1.done, if1.result, if1.found, if1.err}, {1'b1, 8'hFF, 1'b1, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_settle3();
    logic [7:0] e;
    a3 = 8'h01;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 5) start3 = 1'b1;
      tick();
      start3 = 1'b0;
      if (k < 24) begin
        e = 8'h80 >> (k / 3);
        total_cnt++;
        if ({if3.trial, if3.busy, if3.done} !== {e, 1'b1, 1'b0})
          $display("FAIL s3_trial_e%0d: got %h expected %h", k, {if3.trial, if3.busy, if3.done}, {e, 1'b1, 1'b0});
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({if3.done, if3.result, if3.found, if3.err, if3.trial} !== {1'b1, 8'h01, 1'b1, 1'b0, 8'h00})
      $display("FAIL s3_done_e24: got %h expected %h", {if3.done, if3.result, if3.found, if3.err, if3.trial},
               {1'b1, 8'h01, 1'b1, 1'b0, 8'h00});
    else pass_cnt++;
    // Start on the done cycle must be accepted.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    total_cnt++;
    if ({if3.trial, if3.busy, if3.done, if3.found} !== {8'h80, 1'b1, 1'b0, 1'b0})
      $display("FAIL s3_b2b_start: got %h expected %h", {if3.trial, if3.busy, if3.done, if3.found}, {8'h80, 1'b1, 1'b0, 1'b0});
    else pass_cnt++;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 23 || k == 24) begin
        total_cnt++;
        if (if3.done !== (k == 24))
          $display("FAIL s3_b2b_done_e%0d: got %b expected %b", k, if3.done, (k == 24));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    a1 = 8'h5A;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    tick();
    total_cnt++;
    if (if1.trial !== 8'h50)
      $display("FAIL mid_trial_e3: got %h expected 50", if1.trial);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({if1.trial, if1.busy, if1.done, if1.result, if1.found, if1.err} !== 20'h0)
      $display("FAIL mid_reset_zero: got %h expected 0", {if1.trial, if1.busy, if1.done, if1.result, if1.found, if1.err});
    else pass_cnt++;
    #2 rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({if1.done, if1.busy, if1.trial} !== 10'h0)
      $display("FAIL mid_no_done: got %h expected 0", {if1.done, if1.busy, if1.trial});
    else pass_cnt++;
    test_match_5a("rerun");
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_match_5a("m5a");
    test_zero();
    test_ff();
    test_settle3();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
